in_class_sched: RTL and testbench
=================================

# in_class_sched

Round-robin scheduler sharing one `in_class` datapath (operands a/b/c, results x/y/z) among NREQ requesters. It accepts one operand triple at a time, holds the triple stable on the datapath inputs, and waits a fixed LATENCY. It then captures x/y/z and returns them tagged with the requester index. It sits between requesting blocks and the single `in_class` instance in the lab top level.

## Interface
- NREQ, 4, number of requesters (2..8).
- LATENCY, 2, edges from operand-launch edge to result-sampling edge (≥1). The default of 2 suits the registered `in_class`.
- IDW, $clog2(NREQ), width of the requester index.

- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  NREQ  per-requester request; held high until the matching gnt bit is seen.
- req_a / req_b / req_c  in  NREQ*16 each  packed operands; requester k uses bits [16k+15:16k].
- gnt  out  NREQ  one-hot, one-cycle pulse: requester k accepted.
- busy  out  1  transaction in flight (WAIT state).
- dp_a / dp_b / dp_c  out  16 each  to datapath a/b/c; registered, stable for the whole transaction.
- dp_x / dp_y / dp_z  in  16 each  from datapath x/y/z.
- rsp_valid  out  1  one-cycle pulse: rsp_* valid.
- rsp_id  out  IDW  index of the requester served.
- rsp_x / rsp_y / rsp_z  out  16 each  captured results; hold until the next capture.

## Operation
- FSM states: IDLE, WAIT.
- **IDLE**, at each edge:
  - If any req bit is set, select the winner, searching upward from rr_ptr with wraparound.
  - Latch the winner's operands into dp_a/b/c and pulse gnt[winner].
  - Latch the winner index into rsp_id_pending and load cnt = LATENCY-1.
  - Set rr_ptr = (winner+1) mod NREQ; go to WAIT.
  - With no req, stay in IDLE; outputs hold.
- **WAIT**, at each edge:
  - If cnt≠0, decrement cnt.
  - If cnt==0, capture dp_x/y/z into rsp_x/y/z, set rsp_id = rsp_id_pending, pulse rsp_valid, and go to IDLE.
- req is ignored throughout WAIT. A requester that drops req before its grant is simply not selected.
- A requester still requesting after its grant is re-queued by round-robin order; no duplicate grant occurs within the same transaction.
- busy = (state==WAIT). dp_* change only at a grant edge.
- Reset values: state IDLE, rr_ptr 0, cnt 0, gnt 0, busy 0, dp_a/b/c 0, rsp_valid 0, rsp_id 0, rsp_x/y/z 0.
- Reset in WAIT aborts the transaction: no rsp_valid for it, and all registers return to reset values on that edge.

## Timing
- Let grant edge = E0. gnt and new dp_* are visible in cycle E0..E1.
- dp_x/y/z are sampled at edge E_LATENCY. rsp_valid is high in cycle E_LATENCY..E_LATENCY+1.
- The next grant is possible at edge E_LATENCY+1, so a back-to-back period is LATENCY+1 cycles.
- A req rising in the cycle after the capture edge is considered at the next IDLE edge; there is no combinational req→gnt path.
- rr_ptr wraps from NREQ-1 to 0.

## Configuration
- `IN_CLASS_SCHED_RR_EN` defined: round-robin arbitration as above.
- `IN_CLASS_SCHED_RR_EN` undefined: fixed priority, where the lowest set req index always wins. rr_ptr is unused and held at 0. All timing is unchanged.

## Test plan
Bench model: dp_x = a&b, dp_y = a|c, dp_z = a+b+c, each registered once (LATENCY=2).

- **Reset:** reset=1 for 3 cycles with req=4'hF → gnt=0, busy=0, rsp_valid=0, dp_a=0, rsp_x=0 throughout.
- **Single request:** req=4'b0100 with a=0x1234, b=0xEDCB, c=0x0F0F →
  - gnt=4'b0100 for exactly 1 cycle and dp_a=0x1234.
  - 2 edges later: rsp_valid for 1 cycle, rsp_id=2, rsp_x=0x0000, rsp_y=0x1F3F, rsp_z=0x0F0E.
- **Round-robin rotation (RR build):** req=4'hF held → grant order 0,1,2,3,0, with successive grants exactly 3 cycles apart and rsp_id matching each grant.
- **Fixed-priority build:** req=4'b1010 held → gnt is always 4'b0010.
- **Abort on reset:** reset pulsed for 1 cycle during WAIT →
  - No rsp_valid for the aborted transaction.
  - After release with req=4'b1001, first gnt=4'b0001 (rr_ptr reset to 0).
- **Requests during WAIT and dropped requests:**
  - req[3] raised and dropped entirely inside WAIT → never granted.
  - req[1] dropped before its turn → skipped, next grant goes to the following set bit.

Source files
------------

// File: rtl/in_class_sched.sv
// ---------------------------------------------------------------------------
// in_class_sched
//
// Shares one in_class datapath (operands a/b/c, results x/y/z) among NREQ
// requesters. One operand triple is accepted at a time and held on dp_a/b/c.
// After LATENCY edges, dp_x/y/z are captured and returned on rsp_x/y/z,
// tagged with the index of the requester that was served.
//
// Build option:
//   IN_CLASS_SCHED_RR_EN  defined   : round-robin arbitration. The search
//                                     starts at rr_ptr and wraps around.
//   IN_CLASS_SCHED_RR_EN  undefined : fixed priority. The lowest set req
//                                     index wins. No rr_ptr exists.
//   Timing is the same in both builds.
//
// Parameters:
//   NREQ     number of requesters (2..8)
//   LATENCY  edges from the operand-launch edge to the result-sampling edge (>=1)
//   IDW      width of the requester index
//
// Ports:
//   clk                    system clock, rising edge
//   reset                  synchronous, active-high
//   req[NREQ]              per-requester request, held until its gnt bit
//   req_a/b/c[NREQ*16]     packed operands; requester k uses [16k+15:16k]
//   gnt[NREQ]              one-hot, single-cycle accept pulse
//   busy                   a transaction is in flight
//   dp_a/b/c[16]           registered operands driven to the datapath
//   dp_x/y/z[16]           results returned by the datapath
//   rsp_valid              single-cycle pulse: rsp_* are valid
//   rsp_id[IDW]            index of the requester that was served
//   rsp_x/y/z[16]          captured results, held until the next capture
// ---------------------------------------------------------------------------
module in_class_sched #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned LATENCY = 2,
    parameter int unsigned IDW     = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*16-1:0]   req_a,
    input  logic [NREQ*16-1:0]   req_b,
    input  logic [NREQ*16-1:0]   req_c,
    output logic [NREQ-1:0]      gnt,
    output logic                 busy,
    output logic [15:0]          dp_a,
    output logic [15:0]          dp_b,
    output logic [15:0]          dp_c,
    input  logic [15:0]          dp_x,
    input  logic [15:0]          dp_y,
    input  logic [15:0]          dp_z,
    output logic                 rsp_valid,
    output logic [IDW-1:0]       rsp_id,
    output logic [15:0]          rsp_x,
    output logic [15:0]          rsp_y,
    output logic [15:0]          rsp_z
);

    // The counter must be able to hold LATENCY-1 and is at least 1 bit wide.
    localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t            r_state;
    logic [CW-1:0]     r_cnt;
    logic [IDW-1:0]    r_id_pending;
    logic [NREQ-1:0]   r_gnt;
    logic              r_busy;
    logic [15:0]       r_dp_a;
    logic [15:0]       r_dp_b;
    logic [15:0]       r_dp_c;
    logic              r_rsp_valid;
    logic [IDW-1:0]    r_rsp_id;
    logic [15:0]       r_rsp_x;
    logic [15:0]       r_rsp_y;
    logic [15:0]       r_rsp_z;
`ifdef IN_CLASS_SCHED_RR_EN
    logic [IDW-1:0]    r_rr_ptr;
`endif

    logic              w_any;
    logic [IDW-1:0]    w_win;
    logic [NREQ-1:0]   w_onehot;
    logic [IDW-1:0]    w_next_ptr;
    logic [15:0]       w_sel_a;
    logic [15:0]       w_sel_b;
    logic [15:0]       w_sel_c;

    // Winner selection. The first set bit found is the winner. Later hits
    // are ignored through the w_any guard.
    always_comb begin : p_arb
        int unsigned k;
        k     = 0;
        w_any = 1'b0;
        w_win = '0;
`ifdef IN_CLASS_SCHED_RR_EN
        for (int unsigned i = 0; i < NREQ; i++) begin
            k = (32'(r_rr_ptr) + i) % NREQ;
            if (!w_any && req[IDW'(k)]) begin
                w_any = 1'b1;
                w_win = IDW'(k);
            end
        end
`else
        for (int unsigned i = 0; i < NREQ; i++) begin
            k = i;
            if (!w_any && req[IDW'(k)]) begin
                w_any = 1'b1;
                w_win = IDW'(k);
            end
        end
`endif
    end

    always_comb begin
        w_onehot   = {{(NREQ-1){1'b0}}, 1'b1} << w_win;
        // Explicit wrap, so that the pointer also wraps correctly when NREQ
        // is not a power of two.
        w_next_ptr = (w_win == IDW'(NREQ - 1)) ? '0 : w_win + IDW'(1);
        // {w_win, 4'b0} equals w_win*16, and the index is wide enough.
        w_sel_a    = req_a[{w_win, 4'b0000} +: 16];
        w_sel_b    = req_b[{w_win, 4'b0000} +: 16];
        w_sel_c    = req_c[{w_win, 4'b0000} +: 16];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_id_pending <= '0;
            r_gnt        <= '0;
            r_busy       <= 1'b0;
            r_dp_a       <= '0;
            r_dp_b       <= '0;
            r_dp_c       <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= '0;
            r_rsp_x      <= '0;
            r_rsp_y      <= '0;
            r_rsp_z      <= '0;
`ifdef IN_CLASS_SCHED_RR_EN
            r_rr_ptr     <= '0;
`endif
        end else begin
            // gnt and rsp_valid are single-cycle pulses.
            r_gnt       <= '0;
            r_rsp_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_gnt        <= w_onehot;
                        r_dp_a       <= w_sel_a;
                        r_dp_b       <= w_sel_b;
                        r_dp_c       <= w_sel_c;
                        r_id_pending <= w_win;
                        r_cnt        <= CW'(LATENCY - 1);
`ifdef IN_CLASS_SCHED_RR_EN
                        r_rr_ptr     <= w_next_ptr;
`endif
                        r_busy       <= 1'b1;
                        r_state      <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CW'(1);
                    end else begin
                        r_rsp_x     <= dp_x;
                        r_rsp_y     <= dp_y;
                        r_rsp_z     <= dp_z;
                        r_rsp_id    <= r_id_pending;
                        r_rsp_valid <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

`ifndef IN_CLASS_SCHED_RR_EN
    // The fixed-priority build has no pointer to update.
    logic w_unused_ptr;
    assign w_unused_ptr = ^w_next_ptr;
`endif

    assign gnt       = r_gnt;
    assign busy      = r_busy;
    assign dp_a      = r_dp_a;
    assign dp_b      = r_dp_b;
    assign dp_c      = r_dp_c;
    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_x     = r_rsp_x;
    assign rsp_y     = r_rsp_y;
    assign rsp_z     = r_rsp_z;

endmodule

// File: tb/tb_in_class_sched.sv
// Directed bench for in_class_sched (NREQ=4, LATENCY=2). The datapath model
// registers a&b, a|c and a+b+c once. Inputs are driven and outputs are
// sampled on the falling edge.
module tb_in_class_sched;

    localparam int unsigned NREQ = 4;
    localparam int unsigned IDW  = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic [NREQ-1:0]   req;
    logic [NREQ*16-1:0] req_a, req_b, req_c;
    logic [NREQ-1:0]   gnt;
    logic              busy;
    logic [15:0]       dp_a, dp_b, dp_c;
    logic [15:0]       dp_x, dp_y, dp_z;
    logic              rsp_valid;
    logic [IDW-1:0]    rsp_id;
    logic [15:0]       rsp_x, rsp_y, rsp_z;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    in_class_sched #(.NREQ(NREQ), .LATENCY(2), .IDW(IDW)) dut (
        .clk(clk), .reset(reset), .req(req),
        .req_a(req_a), .req_b(req_b), .req_c(req_c),
        .gnt(gnt), .busy(busy),
        .dp_a(dp_a), .dp_b(dp_b), .dp_c(dp_c),
        .dp_x(dp_x), .dp_y(dp_y), .dp_z(dp_z),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id),
        .rsp_x(rsp_x), .rsp_y(rsp_y), .rsp_z(rsp_z)
    );

    // Registered datapath model
    always_ff @(posedge clk) begin
        dp_x <= dp_a & dp_b;
        dp_y <= dp_a | dp_c;
        dp_z <= dp_a + dp_b + dp_c;
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = '0;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req   = 4'hF;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (gnt !== 4'h0) begin errors++; $display("FAIL reset_gnt: got %b expected 0000", gnt); end
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
            checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
            checks++; if (dp_a !== 16'h0) begin errors++; $display("FAIL reset_dp_a: got %h expected 0000", dp_a); end
            checks++; if (rsp_x !== 16'h0) begin errors++; $display("FAIL reset_rsp_x: got %h expected 0000", rsp_x); end
        end
        req   = '0;
        reset = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        req_a[32 +: 16] = 16'h1234;
        req_b[32 +: 16] = 16'hEDCB;
        req_c[32 +: 16] = 16'h0F0F;
        req = 4'b0100;
        step();  // after grant edge E0
        checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL single_gnt: got %b expected 0100", gnt); end
        checks++; if (dp_a !== 16'h1234) begin errors++; $display("FAIL single_dp_a: got %h expected 1234", dp_a); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b expected 1", busy); end
        req = '0;
        step();  // after E1
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL single_gnt_pulse: got %b expected 0000", gnt); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid: got %b expected 0", rsp_valid); end
        step();  // after E2
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL single_rsp_valid: got %b expected 1", rsp_valid); end
        checks++; if (rsp_id !== 2'd2) begin errors++; $display("FAIL single_rsp_id: got %0d expected 2", rsp_id); end
        checks++; if (rsp_x !== 16'h0000) begin errors++; $display("FAIL single_rsp_x: got %h expected 0000", rsp_x); end
        checks++; if (rsp_y !== 16'h1F3F) begin errors++; $display("FAIL single_rsp_y: got %h expected 1f3f", rsp_y); end
        checks++; if (rsp_z !== 16'h0F0E) begin errors++; $display("FAIL single_rsp_z: got %h expected 0f0e", rsp_z); end
        step();  // after E3
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_valid_pulse: got %b expected 0", rsp_valid); end
        checks++; if (rsp_y !== 16'h1F3F) begin errors++; $display("FAIL single_rsp_hold: got %h expected 1f3f", rsp_y); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_end: got %b expected 0", busy); end
    endtask

    task automatic load_distinct_operands();
        for (int k = 0; k < 4; k++) begin
            req_a[16*k +: 16] = 16'h00F0 + 16'(k);
            req_b[16*k +: 16] = 16'h000F;
            req_c[16*k +: 16] = 16'h0000;
        end
    endtask

`ifdef IN_CLASS_SCHED_RR_EN
    task automatic test_rr_rotation();
        int unsigned order [5] = '{0, 1, 2, 3, 0};
        logic [3:0]  exp_g;
        logic [15:0] exp_x;
        do_reset();
        load_distinct_operands();
        req = 4'hF;
        for (int g = 0; g < 5; g++) begin
            exp_g = 4'b0001 << order[g];
            exp_x = 16'(order[g]);   // (0x00F0+k) & 0x000F
            step();
            checks++; if (gnt !== exp_g) begin errors++; $display("FAIL rr_gnt%0d: got %b expected %b", g, gnt, exp_g); end
            step();
            checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL rr_gap%0d: got %b expected 0000", g, gnt); end
            step();
            checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL rr_gap_b%0d: got %b expected 0000", g, gnt); end
            checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL rr_valid%0d: got %b expected 1", g, rsp_valid); end
            checks++; if (rsp_id !== IDW'(order[g])) begin errors++; $display("FAIL rr_id%0d: got %0d expected %0d", g, rsp_id, order[g]); end
            checks++; if (rsp_x !== exp_x) begin errors++; $display("FAIL rr_x%0d: got %h expected %h", g, rsp_x, exp_x); end
        end
        req = '0;
        step();
    endtask
`else
    task automatic test_fixed_priority();
        do_reset();
        load_distinct_operands();
        req = 4'b1010;
        for (int g = 0; g < 4; g++) begin
            step();
            checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL fp_gnt%0d: got %b expected 0010", g, gnt); end
            step();
            step();
            checks++; if (rsp_id !== 2'd1) begin errors++; $display("FAIL fp_id%0d: got %0d expected 1", g, rsp_id); end
            checks++; if (rsp_x !== 16'h0001) begin errors++; $display("FAIL fp_x%0d: got %h expected 0001", g, rsp_x); end
        end
        req = '0;
        step();
    endtask
`endif

    task automatic test_abort();
        do_reset();
        load_distinct_operands();
        req = 4'b0100;
        step();  // after E0, WAIT
        checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL abort_gnt: got %b expected 0100", gnt); end
        req   = '0;
        reset = 1'b1;
        step();  // after E1 (reset)
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy); end
        checks++; if (dp_a !== 16'h0) begin errors++; $display("FAIL abort_dp_a: got %h expected 0000", dp_a); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL abort_valid_a: got %b expected 0", rsp_valid); end
        reset = 1'b0;
        req   = 4'b1001;
        step();  // after E2: the aborted response would have appeared here
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL abort_valid_b: got %b expected 0", rsp_valid); end
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL abort_regrant: got %b expected 0001", gnt); end
        req = '0;
        step();
        step();
        checks++; if (rsp_id !== 2'd0) begin errors++; $display("FAIL abort_new_id: got %0d expected 0", rsp_id); end
        step();
    endtask

    task automatic test_wait_and_drop();
        // req[3] is raised and dropped entirely inside WAIT.
        do_reset();
        load_distinct_operands();
        req = 4'b0001;
        step();  // after E0
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL wd_gnt0: got %b expected 0001", gnt); end
        req = 4'b1000;
        step();  // after E1
        req = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL wd_no_gnt%0d: got %b expected 0000", i, gnt); end
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wd_idle: got %b expected 0", busy); end

        // req[1] dropped before its turn.
        do_reset();
        req = 4'b0111;
        step();  // after E0
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL drop_gnt0: got %b expected 0001", gnt); end
        req = 4'b0100;
        step();
        step();  // after E2
        checks++; if (rsp_id !== 2'd0) begin errors++; $display("FAIL drop_id0: got %0d expected 0", rsp_id); end
        step();  // after E3
        checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL drop_skip: got %b expected 0100", gnt); end
        req = '0;
        step();
        step();
        checks++; if (rsp_id !== 2'd2) begin errors++; $display("FAIL drop_id2: got %0d expected 2", rsp_id); end
    endtask

    initial begin
        reset = 1'b1;
        req   = '0;
        req_a = {16'hAAAA, 16'h5555, 16'h3333, 16'h7777};
        req_b = {16'h1111, 16'h2222, 16'h4444, 16'h8888};
        req_c = {16'h0101, 16'h0202, 16'h0404, 16'h0808};
        test_reset();
        test_single();
`ifdef IN_CLASS_SCHED_RR_EN
        test_rr_rotation();
`else
        test_fixed_priority();
`endif
        test_abort();
        test_wait_and_drop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end

endmodule
